serial_parity_inserter: RTL

- Sequential stage that consumes a serial bit stream and inserts a computed parity bit after every FRAME_LEN data bits.
- Sits directly downstream of the xor/mux combinational cells; its parity accumulator is a 1-bit xor feedback loop built from those cells.
- Upstream and downstream sides use valid/ready handshakes, and the output is registered.

---
 rtl/serial_parity_pkg.sv | 12 +
 rtl/parity_accumulator.sv | 27 ++
 rtl/serial_parity_inserter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and limits for the serial parity inserter: FSM state encoding
// and the largest supported frame length.
package serial_parity_pkg;

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } parity_state_t;

    localparam int MAX_FRAME_LEN = 256;

endpackage : serial_parity_pkg

// File: rtl/parity_accumulator.sv
// One-bit running parity: xor-folds accepted data bits, cleared once the
// parity bit of a frame has been issued.
module parity_accumulator (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic acc_out
);

    logic acc_q;

    // Clear wins over enable: the frame boundary never folds in a data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (clear) begin
            acc_q <= 1'b0;
        end else if (en) begin
            acc_q <= acc_q ^ bit_in;
        end
    end

    assign acc_out = acc_q;

endmodule : parity_accumulator

// File: rtl/serial_parity_inserter.sv
// Serial stream stage that forwards FRAME_LEN data bits, then inserts one parity
// bit. Optional macro SERIAL_PARITY_INSERTER_ERR_INJECT_EN adds an inject_err input.
module serial_parity_inserter
    import serial_parity_pkg::*;
#(
    parameter int FRAME_LEN  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    output logic up_ready,
    input  logic up_data,
    output logic down_valid,
    input  logic down_ready,
    output logic down_data,
    output logic down_is_parity
`ifdef SERIAL_PARITY_INSERTER_ERR_INJECT_EN
    ,
    input  logic inject_err
`endif
);

    localparam int                 CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || FRAME_LEN > MAX_FRAME_LEN) begin : g_bad_frame_len
        $error("serial_parity_inserter: FRAME_LEN out of range 2..%0d", MAX_FRAME_LEN);
    end

    parity_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_valid_q, down_valid_d;
    logic             down_data_q, down_data_d;
    logic             down_is_parity_q, down_is_parity_d;

    logic acc;
    logic acc_en;
    logic acc_clear;
    logic slot_free;
    logic parity_bit;

    parity_accumulator u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear),
        .en      (acc_en),
        .bit_in  (up_data),
        .acc_out (acc)
    );

    assign slot_free = !down_valid_q || down_ready;

`ifdef SERIAL_PARITY_INSERTER_ERR_INJECT_EN
    assign parity_bit = acc ^ ODD_PARITY ^ inject_err;
`else
    assign parity_bit = acc ^ ODD_PARITY;
`endif

    always_comb begin
        // NOTE: every signal driven here is given a default first, so no path can infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        down_valid_d     = down_valid_q;
        down_data_d      = down_data_q;
        down_is_parity_d = down_is_parity_q;
        up_ready         = 1'b0;
        acc_en           = 1'b0;
        acc_clear        = 1'b0;

        // A completed output handshake empties the register unless refilled below.
        if (down_valid_q && down_ready) begin
            down_valid_d = 1'b0;
        end

        unique case (state_q)
            S_DATA: begin
                up_ready = slot_free;
                if (up_valid && slot_free) begin
                    down_data_d      = up_data;
                    down_is_parity_d = 1'b0;
                    down_valid_d     = 1'b1;
                    acc_en           = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (slot_free) begin
                    down_data_d      = parity_bit;
                    down_is_parity_d = 1'b1;
                    down_valid_d     = 1'b1;
                    acc_clear        = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q          <= S_DATA;
            cnt_q            <= '0;
            down_valid_q     <= 1'b0;
            down_data_q      <= 1'b0;
            down_is_parity_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            down_valid_q     <= down_valid_d;
            down_data_q      <= down_data_d;
            down_is_parity_q <= down_is_parity_d;
        end
    end

    assign down_valid     = down_valid_q;
    assign down_data      = down_data_q;
    assign down_is_parity = down_is_parity_q;

endmodule : serial_parity_inserter
